// File: rtl/rv_pkg.sv
// Shared RV32M definitions: funct3 operation encodings, mul/div FSM states
// and per-operation operand signedness helpers.
package rv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    function automatic logic op_is_div(input muldiv_op_t op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input muldiv_op_t op);
        return op[2] & op[1];
    endfunction

    function automatic logic op_a_signed(input muldiv_op_t op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_b_signed(input muldiv_op_t op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/rv_muldiv_step.sv
// One radix-2 iteration on the {hi, lo} working pair: shift-add multiply or
// restoring-divide step; purely combinational, no handshake.
module rv_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    always_comb begin
        w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : '0);
        w_shift = {i_hi, i_lo[WIDTH-1]};
        w_ge    = (w_shift >= {1'b0, i_opnd});
        // Partial remainder stays below the divisor, so the W-bit difference never wraps when used.
        w_diff  = w_shift[WIDTH-1:0] - i_opnd;
        if (i_is_div) begin
            o_hi = w_ge ? w_diff : w_shift[WIDTH-1:0];
            o_lo = {i_lo[WIDTH-2:0], w_ge};
        end else begin
            o_hi = w_sum[WIDTH:1];
            o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/rv_muldiv.sv
// Iterative RV32M multiply/divide: WIDTH+1 cycles accept-to-valid (1 for div-by-zero/overflow);
// result holds under out_ready=0 and no new request is taken until the result is consumed.
module rv_muldiv
    import rv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    muldiv_state_t    r_state;
    muldiv_op_t       r_op;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_result;
    logic             r_neg_sgn;
    logic             r_neg_rem;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    muldiv_op_t         w_op;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_min;
    logic               w_b_zero;
    logic               w_ovf;
    logic               w_special;
    logic [WIDTH-1:0]   w_special_res;
    logic [WIDTH-1:0]   w_step_hi;
    logic [WIDTH-1:0]   w_step_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_final;

    always_comb begin
        w_op     = muldiv_op_t'(op);
        w_a_neg  = op_a_signed(w_op) & a[WIDTH-1];
        w_b_neg  = op_b_signed(w_op) & b[WIDTH-1];
        w_a_mag  = w_a_neg ? -a : a;
        w_b_mag  = w_b_neg ? -b : b;
        w_min    = {1'b1, {(WIDTH-1){1'b0}}};
        w_b_zero = (b == '0);
        w_ovf    = ((w_op == OP_DIV) || (w_op == OP_REM)) && (a == w_min) && (b == '1);
        w_special = op_is_div(w_op) && (w_b_zero || w_ovf);
        if (w_b_zero) begin
            w_special_res = op_is_rem(w_op) ? a : '1;
        end else begin
            w_special_res = op_is_rem(w_op) ? '0 : a;
        end
    end

    rv_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div (op_is_div(r_op)),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .i_opnd   (r_opnd),
        .o_hi     (w_step_hi),
        .o_lo     (w_step_lo)
    );

    // Sign fix-up is applied to the last iteration's outputs so it lands on the same edge.
    always_comb begin
        w_prod     = {w_step_hi, w_step_lo};
        w_prod_fix = r_neg_sgn ? -w_prod : w_prod;
        w_quot     = r_neg_sgn ? -w_step_lo : w_step_lo;
        w_rem      = r_neg_rem ? -w_step_hi : w_step_hi;
        case (r_op)
            OP_MUL:                       w_final = w_prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              w_final = w_quot;
            default:                      w_final = w_rem;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_op        <= OP_MUL;
            r_cnt       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_opnd      <= '0;
            r_result    <= '0;
            r_neg_sgn   <= 1'b0;
            r_neg_rem   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op       <= w_op;
                        r_neg_sgn  <= w_a_neg ^ w_b_neg;
                        r_neg_rem  <= w_a_neg;
                        r_hi       <= '0;
                        r_opnd     <= op_is_div(w_op) ? w_b_mag : w_a_mag;
                        r_lo       <= op_is_div(w_op) ? w_a_mag : w_b_mag;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (w_special) begin
                            r_result    <= w_special_res;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_cnt   <= CW'(WIDTH - 1);
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_hi <= w_step_hi;
                    r_lo <= w_step_lo;
                    if (r_cnt == '0) begin
                        r_result    <= w_final;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign result    = r_result;

endmodule

// File: tb/tb_rv_muldiv.sv
// Bench for rv_muldiv: directed vector table, stall/abort sequences, a WIDTH=8
// instance, and random operations checked against an arithmetic reference.
module tb_rv_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [2:0]  op;
    logic [31:0] a, b, result;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, result8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    rv_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op8), .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .busy(busy8)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [31:0] lat;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // RV32M semantics straight from the ISA rules using 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x,
                                              input logic [31:0] y);
        longint      sx, sy;
        logic [63:0] p;
        logic [31:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = '0;
        r  = '0;
        case (f)
            3'd0: begin p = sx * sy; r = p[31:0]; end
            3'd1: begin p = sx * sy; r = p[63:32]; end
            3'd2: begin p = sx * longint'({32'b0, y}); r = p[63:32]; end
            3'd3: begin p = {32'b0, x} * {32'b0, y}; r = p[63:32]; end
            3'd4: begin
                if (y == 0) r = 32'hFFFF_FFFF;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = x;
                else r = 32'(sx / sy);
            end
            3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) r = x;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'd0;
                else r = 32'(sx % sy);
            end
            default: r = (y == 0) ? x : x % y;
        endcase
        return r;
    endfunction

    // Issues one request, scrambles operands after accept, waits (bounded) for the result.
    task automatic run32(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output int lat);
        @(negedge clk);
        in_valid = 1'b1; op = f; a = x; b = y; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        res = result;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run8(input logic [2:0] f, input logic [7:0] x, input logic [7:0] y,
                        output logic [7:0] res, output int lat);
        @(negedge clk);
        in_valid8 = 1'b1; op8 = f; a8 = x; b8 = y; out_ready8 = 1'b0;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (out_valid8) break;
        end
        res = result8;
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        out_ready8 = 1'b0;
    endtask

    initial begin
        logic [31:0] res, x, y, exp_lat;
        logic [7:0]  res8;
        logic [2:0]  f;
        logic        stable;
        int          lat;

        tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 32'd33};
        tbl[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd33};
        tbl[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd33};
        tbl[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'd33};
        tbl[4]  = '{3'd4, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA, 32'd33};
        tbl[5]  = '{3'd6, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, 32'd33};
        tbl[6]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd1};
        tbl[7]  = '{3'd7, 32'd5,         32'd0,         32'd5,         32'd1};
        tbl[8]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1};
        tbl[9]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'd1};
        tbl[10] = '{3'd4, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 32'd33};
        tbl[11] = '{3'd6, 32'd20,        32'hFFFF_FFFD, 32'd2,         32'd33};
        tbl[12] = '{3'd4, 32'd7,         32'd0,         32'hFFFF_FFFF, 32'd1};
        tbl[13] = '{3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'd1};

        reset = 1'b1;
        in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b0;
        in_valid8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; out_ready8 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run32(tbl[i].op, tbl[i].a, tbl[i].b, res, lat);
            check($sformatf("vec%0d_result", i), res, tbl[i].exp);
            check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
        end

        // Stall the output for 10 cycles.
        @(negedge clk);
        in_valid = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (lat < 100 && !out_valid) begin
            @(negedge clk);
            lat++;
        end
        check("stall_valid_seen", out_valid, 1);
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (result !== 32'd15 || in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1)
                stable = 1'b0;
        end
        check("stall_hold", stable, 1);
        check("stall_result", result, 32'd15);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("hs_in_ready", in_ready, 1);
        check("hs_out_valid", out_valid, 0);
        check("hs_busy", busy, 0);

        // Abort mid-RUN with an asynchronous reset.
        @(negedge clk);
        in_valid = 1'b1; op = 3'd0; a = 32'd123; b = 32'd456;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("run_busy", busy, 1);
        check("run_in_ready", in_ready, 0);
        #2 reset = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        run32(3'd0, 32'd3, 32'd4, res, lat);
        check("after_abort_mul", res, 32'd12);
        check("after_abort_lat", lat, 33);

        run8(3'd5, 8'd200, 8'd7, res8, lat);
        check("w8_divu", res8, 8'd28);
        check("w8_divu_lat", lat, 9);
        run8(3'd7, 8'd200, 8'd7, res8, lat);
        check("w8_remu", res8, 8'd4);
        check("w8_remu_lat", lat, 9);

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            x = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 3))
                0:       y = 32'd0;
                1:       y = 32'($urandom_range(1, 15));
                2:       y = 32'hFFFF_FFFF;
                default: y = $urandom;
            endcase
            exp_lat = (f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
                      ? 32'd1 : 32'd33;
            run32(f, x, y, res, lat);
            check($sformatf("rnd%0d_op%0d_%h_%h", i, f, x, y), res, ref_model(f, x, y));
            check($sformatf("rnd%0d_latency", i), lat, exp_lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
